per_tx_handshake: RTL and testbench

//  Peripheral-side transmitter for the return path, peripheral -> CPU.

---
 rtl/per_tx_handshake.sv | 121 ++++++++++++
 tb/tb_per_tx_handshake.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/per_tx_handshake.sv
// per_tx_handshake: peripheral->CPU transmitter, a small FIFO drained over a send/ack 4-phase handshake
// Ports:
//   per_clock, per_reset_n     clock (posedge) and asynchronous active-low reset
//   per_wr_en, per_wr_dados    local push into the FIFO
//   per_full, per_wr_drop      FIFO full flag and rejected-push pulse
//   per_send, per_dados        handshake request and the word it carries (0 when idle)
//   per_ack                    receiver acknowledge
//   per_timeout_err            sticky flag: a request went unacknowledged for TIMEOUT cycles
//   per_err_clr                clears per_timeout_err
module per_tx_handshake #(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              per_clock,
    input  logic              per_reset_n,
    input  logic              per_wr_en,
    input  logic [DATA_W-1:0] per_wr_dados,
    output logic              per_full,
    output logic              per_wr_drop,
    output logic              per_send,
    output logic [DATA_W-1:0] per_dados,
    input  logic              per_ack,
    output logic              per_timeout_err,
    input  logic              per_err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    // The counter holds the number of ack-less SEND cycles already spent,
    // so the last permitted one is seen when it equals TIMEOUT-1.
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              send_q, send_d, full_q, full_d, drop_q, drop_d, err_q, err_d;
    logic [DATA_W-1:0] dados_q, dados_d;
    logic              push, pop, timeout;

    // Fullness is judged on the count at the start of the cycle, so a push
    // into a full FIFO is dropped even when a pop happens in the same cycle.
    assign push    = per_wr_en && (count_q != FULL_CNT);
    assign pop     = (state_q == SEND) && per_ack;
    assign timeout = (TIMEOUT > 0) && (state_q == SEND) && !per_ack && (cnt_q == TLAST);

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = per_wr_dados;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        full_d   = count_d == FULL_CNT;
        drop_d   = per_wr_en && !push;
        state_d  = state_q;
        send_d   = send_q;
        dados_d  = dados_q;
        cnt_d    = cnt_q;
        // A timeout raised in the same cycle as a clear keeps the flag set.
        err_d    = timeout ? 1'b1 : (per_err_clr ? 1'b0 : err_q);
        case (state_q)
            IDLE: if (count_q != '0) begin
                state_d = SEND;
                send_d  = 1'b1;
                dados_d = mem_q[rd_ptr_q];
                cnt_d   = '0;
            end
            SEND: if (per_ack || timeout) begin
                // On timeout the head is left in place and offered again from IDLE.
                state_d = per_ack ? RELEASE : IDLE;
                send_d  = 1'b0;
                dados_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            RELEASE: state_d = per_ack ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge per_clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge per_clock or negedge per_reset_n) begin
        if (!per_reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            send_q   <= 1'b0;
            dados_q  <= '0;
            full_q   <= 1'b0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            send_q   <= send_d;
            dados_q  <= dados_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    assign per_send        = send_q;
    assign per_dados       = dados_q;
    assign per_full        = full_q;
    assign per_wr_drop     = drop_q;
    assign per_timeout_err = err_q;
endmodule

// File: tb/tb_per_tx_handshake.sv
// tb_per_tx_handshake: directed bench with a queue-based reference model checked every cycle
module tb_per_tx_handshake;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 0, rst_n = 0, wr_en = 0, err_clr = 0;
    logic [3:0] wr_d = 0;
    logic       full, drop, send, err, ack;
    logic [3:0] dados;

    bit auto_ack = 0, man_ack = 0, send_seen = 0;
    assign ack = auto_ack ? send_seen : man_ack;

    int         checks = 0, errors = 0;
    int         hi_total = 0, rx_n = 0;
    logic [3:0] rx [256];

    always #5 clk = ~clk;

    per_tx_handshake #(.DATA_W(4), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .per_clock(clk), .per_reset_n(rst_n), .per_wr_en(wr_en), .per_wr_dados(wr_d),
        .per_full(full), .per_wr_drop(drop), .per_send(send), .per_dados(dados),
        .per_ack(ack), .per_timeout_err(err), .per_err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the phase of the current offer.
    // phase 0: nothing offered, 1: word offered awaiting ack, 2: waiting for ack to fall.
    logic [3:0] mq[$];
    int         m_phase = 0, m_wait = 0;
    logic       m_send = 0, m_full = 0, m_drop = 0, m_err = 0, m_to = 0;
    logic [3:0] m_dados = 0;
    bit         was_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_phase = 0; m_wait = 0; m_send = 0; m_dados = 0;
            m_full = 0; m_drop = 0; m_err = 0;
        end else begin
            was_full = mq.size() == DEPTH;
            m_drop = wr_en && was_full;
            m_to = 0;
            if (m_phase == 0 && mq.size() > 0) begin
                m_phase = 1; m_send = 1; m_dados = mq[0]; m_wait = 0;
            end else if (m_phase == 1 && ack) begin
                void'(mq.pop_front());
                m_phase = 2; m_send = 0; m_dados = 0;
            end else if (m_phase == 1 && m_wait + 1 == TIMEOUT) begin
                m_to = 1; m_phase = 0; m_send = 0; m_dados = 0;
            end else if (m_phase == 1) begin
                m_wait++;
            end else if (m_phase == 2 && !ack) begin
                m_phase = 0;
            end
            m_err = m_to ? 1'b1 : (err_clr ? 1'b0 : m_err);
            if (wr_en && !was_full) mq.push_back(wr_d);
            m_full = mq.size() == DEPTH;
        end
    end

    always @(negedge clk) begin
        chk("send", send, m_send);
        chk("dados", dados, m_dados);
        chk("full", full, m_full);
        chk("drop", drop, m_drop);
        chk("err", err, m_err);
        if (send && !send_seen && rx_n < 256) begin
            rx[rx_n] = dados;
            rx_n++;
        end
        if (send) hi_total++;
        send_seen = send;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_send(input logic lvl, input string name);
        int k = 0;
        while (send !== lvl && k < 50) begin
            tick(1);
            k++;
        end
        chk(name, send, lvl);
    endtask

    task automatic push(input logic [3:0] d);
        wr_en = 1; wr_d = d;
        tick(1);
        wr_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, r0;
        logic [3:0] exp5 [5];
        exp5 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8};
        tick(2);
        chk("rst_send", send, 0);
        chk("rst_dados", dados, 0);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        tick(2);

        // single word, ack two cycles after request, released one cycle later
        h0 = hi_total; r0 = rx_n;
        push(4'h5);
        wait_send(1, "t1_rise");
        tick(2);
        man_ack = 1;
        tick(1);
        man_ack = 0;
        wait_send(0, "t1_fall");
        tick(3);
        chk("t1_high_cycles", hi_total - h0, 3);
        chk("t1_word", rx[r0], 4'h5);
        chk("t1_words", rx_n - r0, 1);
        chk("t1_full", full, 0);
        chk("t1_err", err, 0);

        // fill, overflow, then drain in order
        r0 = rx_n;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1; wr_d = 4'(i);
            if (i == 5) chk("t2_full", full, 1);
            tick(1);
        end
        wr_en = 0;
        chk("t2_drop", drop, 1);
        auto_ack = 1;
        tick(30);
        auto_ack = 0;
        chk("t2_words", rx_n - r0, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", rx[r0 + i], 32'(i + 1));
        chk("t2_full_drained", full, 0);

        // timeout, retry, set-wins against clear
        h0 = hi_total; r0 = rx_n;
        push(4'h9);
        wait_send(1, "t3_rise");
        wait_send(0, "t3_fall");
        chk("t3_high_cycles", hi_total - h0, 16);
        chk("t3_err_set", err, 1);
        wait_send(1, "t3_retry");
        chk("t3_retry_word", dados, 4'h9);
        man_ack = 1;
        wait_send(0, "t3_retry_fall");
        man_ack = 0;
        tick(2);
        chk("t3_err_sticky", err, 1);
        push(4'hE);
        wait_send(1, "t3b_rise");
        tick(15);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        chk("t3b_timed_out", send, 0);
        chk("t3b_set_wins", err, 1);
        wait_send(1, "t3b_retry");
        man_ack = 1;
        wait_send(0, "t3b_retry_fall");
        man_ack = 0;
        tick(2);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        chk("t3_err_cleared", err, 0);

        // ack already high at request: single-cycle offer, then held in release
        h0 = hi_total; r0 = rx_n;
        man_ack = 1;
        push(4'hA);
        push(4'hB);
        tick(10);
        chk("t4_high_cycles", hi_total - h0, 1);
        chk("t4_word", rx[r0], 4'hA);
        chk("t4_words", rx_n - r0, 1);
        man_ack = 0;
        wait_send(1, "t4_second");
        chk("t4_second_word", dados, 4'hB);
        man_ack = 1;
        wait_send(0, "t4_second_fall");
        man_ack = 0;
        tick(3);

        // push/pop collisions at count 4 and count 3
        r0 = rx_n;
        for (int i = 1; i <= 4; i++) push(4'(i));
        chk("t5_full", full, 1);
        man_ack = 1; wr_en = 1; wr_d = 4'h7;
        tick(1);
        wr_en = 0; man_ack = 0;
        chk("t5_drop", drop, 1);
        chk("t5_full_after_pop", full, 0);
        wait_send(1, "t5_next");
        man_ack = 1; wr_en = 1; wr_d = 4'h8;
        tick(1);
        wr_en = 0; man_ack = 0;
        chk("t5_no_drop", drop, 0);
        chk("t5_not_full", full, 0);
        auto_ack = 1;
        tick(30);
        auto_ack = 0;
        chk("t5_words", rx_n - r0, 5);
        for (int i = 0; i < 5; i++) chk("t5_order", rx[r0 + i], exp5[i]);

        // asynchronous reset in the middle of a request
        push(4'hC);
        wait_send(1, "t6_rise");
        #2 rst_n = 0;
        #1;
        chk("t6_send_async", send, 0);
        chk("t6_dados_async", dados, 0);
        tick(1);
        rst_n = 1;
        tick(5);
        chk("t6_idle_after", send, 0);
        chk("t6_empty_after", full, 0);
        push(4'hD);
        wait_send(1, "t6_restart");
        chk("t6_restart_word", dados, 4'hD);
        man_ack = 1;
        wait_send(0, "t6_restart_fall");
        man_ack = 0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
